// File: rtl/core_boot_pkg.sv
// Shared types and default constants for the core boot controller:
// FSM state encoding plus the default parameter values used by the top.
package core_boot_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_MAX_CYCLES  = 1000;
    localparam int DEF_HALT_REPEAT = 2;
    localparam int PC_W            = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOADED = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } boot_state_e;

    // States in which the loader handshake is open.
    function automatic logic accepts_load(input boot_state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD);
    endfunction

    // States in which the core is held in reset.
    function automatic logic holds_core_reset(input boot_state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_LOADED);
    endfunction

endpackage

// File: rtl/core_boot_ctrl_pc_halt_detect.sv
// Detects a halted core: the PC repeats its previous-cycle value for
// HALT_REPEAT consecutive enabled cycles. halt_o is a same-cycle pulse.
module pc_halt_detect
    import core_boot_pkg::*;
#(
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            clear_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            halt_o
);

    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(HALT_REPEAT);

    logic [PC_W-1:0] pc_q;
    logic            pc_valid_q;
    logic [RW-1:0]   rep_q;
    logic [RW-1:0]   rep_d;
    logic            same_pc;

    // The first enabled cycle has no previous PC to compare against.
    assign same_pc = en_i && pc_valid_q && (pc_i == pc_q);
    assign halt_o  = same_pc && ((int'(rep_q) + 1) >= HALT_REPEAT);

    always_comb begin
        rep_d = rep_q;
        if (clear_i) begin
            rep_d = '0;
        end else if (en_i) begin
            if (!same_pc) begin
                rep_d = '0;
            end else if (rep_q != REP_MAX) begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            rep_q      <= '0;
        end else begin
            rep_q <= rep_d;
            if (clear_i) begin
                pc_valid_q <= 1'b0;
            end else if (en_i) begin
                pc_q       <= pc_i;
                pc_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot controller: streams a program image into instruction memory, then
// releases the core and runs it until it halts or a cycle budget expires.
module core_boot_ctrl
    import core_boot_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_LAST,
    input  logic              START,
    input  logic              CLEAR,
    input  logic [PC_W-1:0]   CORE_PC,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_DATAIN,
    output logic              CORE_RESET_N,
    output logic              CORE_EN,
    output logic [CNT_W-1:0]  RUN_CYCLES,
    output logic              DONE,
    output logic              HALTED,
    output logic              TIMEOUT,
    output logic              OVERFLOW,
    output logic [2:0]        STATE
);

    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CYCLE_LIM = CNT_W'(MAX_CYCLES);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              load_ready_q, load_ready_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              core_en_q, core_en_d;
    logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
    logic              done_q, done_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;

    logic              xfer;
    logic              run_entry;
    logic              halt_pulse;

    // The handshake uses the registered READY, so it is only open in IDLE/LOAD.
    assign xfer      = LOAD_VALID && load_ready_q;
    assign run_entry = (state_q != ST_RUN) && (state_d == ST_RUN);

    pc_halt_detect #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .en_i    (state_q == ST_RUN),
        .clear_i (run_entry),
        .pc_i    (CORE_PC),
        .halt_o  (halt_pulse)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        run_cycles_d = run_cycles_q;
        done_d       = done_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        overflow_d   = overflow_q;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (xfer) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = LOAD_DATA;
                    // The pointer saturates at the top of memory instead of wrapping.
                    if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (LOAD_LAST) begin
                        state_d = ST_LOADED;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d    = ST_LOADED;
                        overflow_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (START && (state_q == ST_IDLE)) begin
                    state_d      = ST_RUN;
                    run_cycles_d = '0;
                end
            end
            ST_LOADED: begin
                if (START) begin
                    state_d      = ST_RUN;
                    run_cycles_d = '0;
                end
            end
            ST_RUN: begin
                run_cycles_d = run_cycles_q + 1'b1;
                // Halt wins over timeout when both land on the same cycle.
                if (halt_pulse) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    halted_d = 1'b1;
                end else if (run_cycles_d == CYCLE_LIM) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (CLEAR) begin
                    state_d      = ST_IDLE;
                    ptr_d        = '0;
                    run_cycles_d = '0;
                    done_d       = 1'b0;
                    halted_d     = 1'b0;
                    timeout_d    = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_ready_d   = accepts_load(state_d);
        core_reset_n_d = !holds_core_reset(state_d);
        core_en_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            load_ready_q   <= 1'b0;
            core_reset_n_q <= 1'b0;
            core_en_q      <= 1'b0;
            run_cycles_q   <= '0;
            done_q         <= 1'b0;
            halted_q       <= 1'b0;
            timeout_q      <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            load_ready_q   <= load_ready_d;
            core_reset_n_q <= core_reset_n_d;
            core_en_q      <= core_en_d;
            run_cycles_q   <= run_cycles_d;
            done_q         <= done_d;
            halted_q       <= halted_d;
            timeout_q      <= timeout_d;
            overflow_q     <= overflow_d;
        end
    end

    assign LOAD_READY   = load_ready_q;
    assign MEM_WE       = mem_we_q;
    assign MEM_ADDRESS  = mem_addr_q;
    assign MEM_DATAIN   = mem_data_q;
    assign CORE_RESET_N = core_reset_n_q;
    assign CORE_EN      = core_en_q;
    assign RUN_CYCLES   = run_cycles_q;
    assign DONE         = done_q;
    assign HALTED       = halted_q;
    assign TIMEOUT      = timeout_q;
    assign OVERFLOW     = overflow_q;
    assign STATE        = state_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl: expected memory writes are queued at issue
// time and popped by a write monitor; status flags are checked at fixed points.
module tb_core_boot_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              LOAD_VALID;
    logic              LOAD_READY;
    logic [DATA_W-1:0] LOAD_DATA;
    logic              LOAD_LAST;
    logic              START;
    logic              CLEAR;
    logic [31:0]       CORE_PC = 32'd0;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDRESS;
    logic [DATA_W-1:0] MEM_DATAIN;
    logic              CORE_RESET_N;
    logic              CORE_EN;
    logic [CNT_W-1:0]  RUN_CYCLES;
    logic              DONE, HALTED, TIMEOUT, OVERFLOW;
    logic [2:0]        STATE;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    int          pc_mode = 0;
    int          pc_idx  = 0;
    logic        prev_en = 1'b0;
    logic [31:0] halt_seq [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
    logic [31:0] prog     [4] = '{32'h00000013, 32'h00100093, 32'h00208113, 32'h0000006F};
    logic [31:0] ovf_prog [5] = '{32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004};

    core_boot_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .MAX_CYCLES  (10),
        .HALT_REPEAT (2)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .LOAD_VALID   (LOAD_VALID),
        .LOAD_READY   (LOAD_READY),
        .LOAD_DATA    (LOAD_DATA),
        .LOAD_LAST    (LOAD_LAST),
        .START        (START),
        .CLEAR        (CLEAR),
        .CORE_PC      (CORE_PC),
        .MEM_WE       (MEM_WE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_DATAIN   (MEM_DATAIN),
        .CORE_RESET_N (CORE_RESET_N),
        .CORE_EN      (CORE_EN),
        .RUN_CYCLES   (RUN_CYCLES),
        .DONE         (DONE),
        .HALTED       (HALTED),
        .TIMEOUT      (TIMEOUT),
        .OVERFLOW     (OVERFLOW),
        .STATE        (STATE)
    );

    always #5 CLK = ~CLK;

    // Tiny core model: mode 0 walks to a self-loop, mode 1 never repeats its PC.
    always @(negedge CLK) begin
        if (CORE_EN === 1'b1) begin
            if (prev_en == 1'b0) pc_idx = 0;
            if (pc_mode == 0) CORE_PC = halt_seq[(pc_idx > 5) ? 5 : pc_idx];
            else              CORE_PC = 32'(pc_idx * 4);
            pc_idx = pc_idx + 1;
        end
        prev_en = (CORE_EN === 1'b1);
    end

    // Write monitor: every MEM_WE pulse must match the oldest expected write.
    always @(negedge CLK) begin : wr_monitor
        wr_t e;
        if (MEM_WE === 1'b1) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_write: addr=%0d data=%08h, no write expected", MEM_ADDRESS, MEM_DATAIN);
            end else begin
                e = exp_q.pop_front();
                if (MEM_ADDRESS !== e.addr || MEM_DATAIN !== e.data) begin
                    bad = bad + 1;
                    $display("FAIL mem_write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                             MEM_ADDRESS, MEM_DATAIN, e.addr, e.data);
                end else begin
                    $display("write ok: addr=%0d data=%08h", MEM_ADDRESS, MEM_DATAIN);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offers n words back to back; the first n_acc of them are expected in memory.
    task automatic send_words(input int n, input int n_acc, input logic last_on_final, input int which);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            LOAD_VALID = 1'b1;
            LOAD_DATA  = (which == 0) ? prog[i] : ovf_prog[i];
            LOAD_LAST  = last_on_final && (i == n - 1);
            if (i < n_acc) exp_q.push_back('{addr: ADDR_W'(i), data: LOAD_DATA});
        end
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        LOAD_LAST  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (DONE !== 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check("done_reached", 32'(DONE), 32'd1);
    endtask

    task automatic pulse(input int which);
        if (which == 0) START = 1'b1; else CLEAR = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        CLEAR = 1'b0;
    endtask

    initial begin
        RESET_N    = 1'b1;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        LOAD_LAST  = 1'b0;
        START      = 1'b0;
        CLEAR      = 1'b0;
        #1 RESET_N = 1'b0;
        #2;
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_load_ready", 32'(LOAD_READY), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_core_reset_n", 32'(CORE_RESET_N), 32'd0);
        check("rst_flags", {28'd0, DONE, HALTED, TIMEOUT, OVERFLOW}, 32'd0);
        check("rst_run_cycles", RUN_CYCLES, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1 check("ready_before_edge", 32'(LOAD_READY), 32'd0);
        @(negedge CLK);
        check("ready_after_edge", 32'(LOAD_READY), 32'd1);

        // Four-word image, LAST on the final word (lands on the top address).
        send_words(4, 4, 1'b1, 0);
        check("loaded_state", 32'(STATE), 32'd2);
        check("loaded_ready", 32'(LOAD_READY), 32'd0);
        check("loaded_no_ovf", 32'(OVERFLOW), 32'd0);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 32'hDEADBEEF;
        @(negedge CLK);
        LOAD_VALID = 1'b0;

        // Run until the core self-loops on PC 12.
        pc_mode = 0;
        pulse(0);
        check("run_state", 32'(STATE), 32'd3);
        check("run_core_en", 32'(CORE_EN), 32'd1);
        check("run_core_reset_n", 32'(CORE_RESET_N), 32'd1);
        wait_done(30);
        check("halt_flag", 32'(HALTED), 32'd1);
        check("halt_no_timeout", 32'(TIMEOUT), 32'd0);
        check("halt_cycles", RUN_CYCLES, 32'd6);
        check("halt_core_en", 32'(CORE_EN), 32'd0);
        check("halt_en_cycles", 32'(pc_idx), 32'd6);
        START = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        check("done_hold_state", 32'(STATE), 32'd4);
        check("done_hold_cycles", RUN_CYCLES, 32'd6);
        pulse(1);
        check("clear_state", 32'(STATE), 32'd0);
        check("clear_flags", {28'd0, DONE, HALTED, TIMEOUT, OVERFLOW}, 32'd0);
        check("clear_cycles", RUN_CYCLES, 32'd0);
        check("clear_ready", 32'(LOAD_READY), 32'd1);

        // START straight from IDLE with a PC that never repeats: timeout.
        pc_mode = 1;
        pulse(0);
        wait_done(30);
        check("to_flag", 32'(TIMEOUT), 32'd1);
        check("to_no_halt", 32'(HALTED), 32'd0);
        check("to_cycles", RUN_CYCLES, 32'd10);
        check("to_core_en", 32'(CORE_EN), 32'd0);
        check("to_en_cycles", 32'(pc_idx), 32'd10);
        pulse(1);
        check("to_clear", {28'd0, DONE, HALTED, TIMEOUT, OVERFLOW}, 32'd0);

        // Five words, no LAST, into a four-word memory.
        send_words(5, 4, 1'b0, 1);
        check("ovf_flag", 32'(OVERFLOW), 32'd1);
        check("ovf_state", 32'(STATE), 32'd2);
        check("ovf_ready", 32'(LOAD_READY), 32'd0);
        pulse(1);
        check("clear_ignored_state", 32'(STATE), 32'd2);
        check("clear_ignored_ovf", 32'(OVERFLOW), 32'd1);
        pc_mode = 0;
        pulse(0);
        wait_done(30);
        check("ovf_sticky", 32'(OVERFLOW), 32'd1);
        pulse(1);
        check("ovf_cleared", 32'(OVERFLOW), 32'd0);

        // Reset during the third load beat: words 0 and 1 land, word 2 must not.
        @(negedge CLK);
        LOAD_VALID = 1'b1; LOAD_DATA = prog[0];
        exp_q.push_back('{addr: 2'd0, data: prog[0]});
        @(negedge CLK);
        LOAD_DATA = prog[1];
        exp_q.push_back('{addr: 2'd1, data: prog[1]});
        @(negedge CLK);
        LOAD_DATA = prog[2];
        #2 RESET_N = 1'b0;
        #1;
        check("abort_state", 32'(STATE), 32'd0);
        check("abort_mem_we", 32'(MEM_WE), 32'd0);
        check("abort_mem_addr", 32'(MEM_ADDRESS), 32'd0);
        check("abort_ready", 32'(LOAD_READY), 32'd0);
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        RESET_N    = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort_idle", 32'(STATE), 32'd0);
        check("abort_ready_back", 32'(LOAD_READY), 32'd1);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_boot_ctrl.md
CORE_BOOT_CTRL -- requirements
Module: core_boot_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, memory word width; ADDR_W, default 10, word-address width, depth 2**ADDR_W; CNT_W, default 32, cycle-counter width; MAX_CYCLES, default 1000, run-cycle timeout; HALT_REPEAT, default 2, consecutive cycles with unchanged PC that mean halt.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- LOAD_VALID  in  1  program word offered.
- LOAD_READY  out  1  controller accepts a word.
- LOAD_DATA  in  DATA_W  program word.
- LOAD_LAST  in  1  final word of image.
- START  in  1  request run.
- CLEAR  in  1  return from DONE to IDLE.
- CORE_PC  in  32  core program counter.
- MEM_WE  out  1  instruction-memory write strobe.
- MEM_ADDRESS  out  ADDR_W  word address.
- MEM_DATAIN  out  DATA_W  write data.
- CORE_RESET_N  out  1  core reset, active low.
- CORE_EN  out  1  core clock enable.
- RUN_CYCLES  out  CNT_W  cycles spent in RUN.
- DONE, HALTED, TIMEOUT, OVERFLOW  out  1 each  status flags.
- STATE  out  3  encoded FSM state.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, LOADED, RUN, DONE; all outputs SHALL be registered.
REQ-004 A transfer SHALL occur on a rising edge where LOAD_VALID and LOAD_READY are both 1; LOAD_READY SHALL be 1 only in IDLE and LOAD.
REQ-005 A transfer SHALL cause MEM_WE=1, MEM_ADDRESS=write pointer and MEM_DATAIN=LOAD_DATA for exactly the next cycle (latency 1); the pointer SHALL then increment by 1.
REQ-006 IDLE SHALL move to LOAD on the first transfer, which is written to address 0.
REQ-007 A transfer with LOAD_LAST=1 SHALL move to LOADED and deassert LOAD_READY from the following cycle.
REQ-008 A transfer at pointer 2**ADDR_W-1 without LOAD_LAST SHALL move to LOADED and set the sticky flag OVERFLOW; the pointer SHALL NOT wrap.
REQ-009 START in LOADED or IDLE SHALL move to RUN on the next edge (IDLE covers a preloaded image); START in LOAD, RUN or DONE SHALL be ignored.
REQ-010 CORE_RESET_N SHALL be 0 in IDLE, LOAD and LOADED, and 1 in RUN and DONE.
REQ-011 CORE_EN SHALL be 1 only in RUN.
REQ-012 RUN_CYCLES SHALL be cleared on entry to RUN and increment by 1 every RUN cycle.
REQ-013 Halt SHALL be detected when CORE_PC equals its previous-cycle value for HALT_REPEAT consecutive RUN cycles; detection SHALL move to DONE with HALTED=1.
REQ-014 When RUN_CYCLES reaches MAX_CYCLES, the FSM SHALL move to DONE with TIMEOUT=1.
REQ-015 If halt and timeout occur in the same cycle, HALTED=1 and TIMEOUT=0.
REQ-016 DONE SHALL hold RUN_CYCLES and all flags stable and set DONE=1.
REQ-017 CLEAR in DONE SHALL return to IDLE and clear the pointer, RUN_CYCLES, DONE, HALTED, TIMEOUT and OVERFLOW; CLEAR in any other state SHALL be ignored.
REQ-018 LOAD_VALID outside IDLE/LOAD SHALL produce no memory write.

Reset
REQ-019 RESET_N=0 SHALL asynchronously force: STATE=IDLE, pointer=0, MEM_WE=0, MEM_ADDRESS=0, MEM_DATAIN=0, CORE_RESET_N=0, CORE_EN=0, RUN_CYCLES=0, all flags 0, LOAD_READY=0.
REQ-020 LOAD_READY SHALL first rise on the first edge after RESET_N deasserts.
REQ-021 Reset asserted mid-LOAD or mid-RUN SHALL abort with no further MEM_WE pulse and no partial-state recovery.

Structure
REQ-022 The state enum and state encoding, and the default parameter constants, SHALL live in the shared package core_boot_pkg.
REQ-023 Halt detection (PC register, repeat counter, halt pulse) SHALL be the sub-module pc_halt_detect.

Verification
REQ-024 Load 4 words 0x00000013, 0x00100093, 0x00208113, 0x0000006F, LAST on the 4th, VALID continuous: MEM_WE pulses at addresses 0..3 with matching data, STATE=LOADED, LOAD_READY=0.
REQ-025 After REQ-024, pulse START; CORE_PC runs 0, 4, 8, 12, 12, 12 with HALT_REPEAT=2: DONE=1, HALTED=1, TIMEOUT=0, RUN_CYCLES frozen.
REQ-026 MAX_CYCLES=10, CORE_PC incrementing every cycle: DONE after 10 RUN cycles, TIMEOUT=1, RUN_CYCLES=10, CORE_EN=0 afterwards.
REQ-027 ADDR_W=2, 5 words with no LAST: writes at addresses 0..3 only, OVERFLOW=1, 5th word not accepted.
REQ-028 RESET_N pulsed low during the 3rd load beat: all outputs at reset values immediately, no write to address 2 after release; CLEAR from DONE returns STATE=IDLE with flags 0.
